regfile_scoreboard: RTL and testbench

Issue-side controller for the DLX three-read/one-write register file. Tracks pending destination writes in a per-register busy scoreboard and stalls issue on RAW/WAW hazards. Arbitrates the single register-file write port between the ALU writeback path and the long-latency memory writeback path. Sits between decode/issue and the register file, driving its `Rd`/`reg_in` write side.

---
 rtl/dlx_pkg.sv | 12 +
 rtl/wb_arbiter.sv | 42 ++++
 rtl/regfile_scoreboard.sv | 118 +++++++++++
 tb/tb_regfile_scoreboard.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_pkg.sv
// Shared types for the DLX register-file issue/writeback slice.
package dlx_pkg;
    localparam int NREGS = 32;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_e;
endpackage

// File: rtl/wb_arbiter.sv
// Two-way round-robin valid/ready arbiter for the register-file write port.
module wb_arbiter
    import dlx_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_valid,
    input  logic       mem_valid,
    output logic [1:0] grant,
    output wb_src_e    src
);
    wb_src_e last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= WB_MEM;
        end else if (|grant) begin
            last_q <= src;
        end
    end

    // Under contention the side that did not win last time gets the port.
    always_comb begin
        grant = '0;
        src   = WB_ALU;
        if (alu_valid && mem_valid) begin
            if (last_q == WB_MEM) begin
                grant = 2'b01;
                src   = WB_ALU;
            end else begin
                grant = 2'b10;
                src   = WB_MEM;
            end
        end else if (alu_valid) begin
            grant = 2'b01;
            src   = WB_ALU;
        end else if (mem_valid) begin
            grant = 2'b10;
            src   = WB_MEM;
        end
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard, long-op counter and hazard stall for the DLX register file,
// driving the register-file write port through a round-robin writeback arbiter.
module regfile_scoreboard
    import dlx_pkg::*;
#(
    parameter int MAX_LONG = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic [4:0]  issue_rs3,
    input  logic [4:0]  issue_rd,
    input  logic        issue_wr,
    input  logic        issue_long,
    output logic        issue_stall,
    input  logic        alu_wb_valid,
    output logic        alu_wb_ready,
    input  logic [4:0]  alu_wb_rd,
    input  logic [31:0] alu_wb_data,
    input  logic        mem_wb_valid,
    output logic        mem_wb_ready,
    input  logic [4:0]  mem_wb_rd,
    input  logic [31:0] mem_wb_data,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic [31:0] busy,
    output logic [3:0]  long_cnt,
    output logic        err_spurious
);
    logic [1:0]       grant;
    wb_src_e          src;
    reg_idx_t         wb_rd;
    word_t            wb_data;
    logic             wb_hit;
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] busy_eff;
    logic [3:0]       long_q;
    logic             err_q;
    logic             fire;
    logic             long_inc;
    logic             long_dec;

    wb_arbiter u_arb (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_wb_valid),
        .mem_valid (mem_wb_valid),
        .grant     (grant),
        .src       (src)
    );

    assign alu_wb_ready = grant[0];
    assign mem_wb_ready = grant[1];

    always_comb begin
        wb_rd    = (src == WB_MEM) ? mem_wb_rd   : alu_wb_rd;
        wb_data  = (src == WB_MEM) ? mem_wb_data : alu_wb_data;
        wb_hit   = (|grant) && (wb_rd != '0);
        rf_we    = wb_hit;
        rf_rd    = (|grant) ? wb_rd   : '0;
        rf_wdata = (|grant) ? wb_data : '0;
        clr_mask = '0;
        if (wb_hit) begin
            clr_mask[wb_rd] = 1'b1;
        end
    end

    // A register released by this cycle's write is readable through the
    // register file's write-through path, so it no longer blocks issue.
    always_comb begin
        busy_eff    = busy_q & ~clr_mask;
        issue_stall = 1'b0;
        if (issue_valid) begin
            if ((issue_rs1 != '0) && busy_eff[issue_rs1]) issue_stall = 1'b1;
            if ((issue_rs2 != '0) && busy_eff[issue_rs2]) issue_stall = 1'b1;
            if ((issue_rs3 != '0) && busy_eff[issue_rs3]) issue_stall = 1'b1;
            if (issue_wr && (issue_rd != '0) && busy_eff[issue_rd]) issue_stall = 1'b1;
            if (issue_wr && issue_long && (long_q == 4'(MAX_LONG))) issue_stall = 1'b1;
        end
    end

    always_comb begin
        fire     = issue_valid && !issue_stall;
        set_mask = '0;
        if (fire && issue_wr && (issue_rd != '0)) begin
            set_mask[issue_rd] = 1'b1;
        end
        long_inc = fire && issue_wr && issue_long && (issue_rd != '0);
        long_dec = grant[1] && (mem_wb_rd != '0) && (long_q != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            long_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= (busy_q & ~clr_mask) | set_mask;
            if (long_inc && !long_dec) begin
                long_q <= long_q + 4'd1;
            end else if (long_dec && !long_inc) begin
                long_q <= long_q - 4'd1;
            end
            if (wb_hit && !busy_q[wb_rd]) begin
                err_q <= 1'b1;
            end
        end
    end

    assign busy         = busy_q;
    assign long_cnt     = long_q;
    assign err_spurious = err_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomized checks of regfile_scoreboard against a behavioural model.
module tb_regfile_scoreboard;
    localparam int MAXL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rs3, issue_rd;
    logic        issue_wr, issue_long, issue_stall;
    logic        alu_wb_valid, alu_wb_ready;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        mem_wb_valid, mem_wb_ready;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [31:0] busy;
    logic [3:0]  long_cnt;
    logic        err_spurious;

    int checks   = 0;
    int failures = 0;

    // Reference state: one flag per register, plain integer counter.
    bit m_busy[32];
    int m_cnt;
    bit m_last_mem;
    bit m_err;

    regfile_scoreboard #(.MAX_LONG(MAXL)) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_rs3    (issue_rs3),
        .issue_rd     (issue_rd),
        .issue_wr     (issue_wr),
        .issue_long   (issue_long),
        .issue_stall  (issue_stall),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_ready (alu_wb_ready),
        .alu_wb_rd    (alu_wb_rd),
        .alu_wb_data  (alu_wb_data),
        .mem_wb_valid (mem_wb_valid),
        .mem_wb_ready (mem_wb_ready),
        .mem_wb_rd    (mem_wb_rd),
        .mem_wb_data  (mem_wb_data),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_wdata     (rf_wdata),
        .busy         (busy),
        .long_cnt     (long_cnt),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rs3 = 0;
        issue_rd = 0; issue_wr = 0; issue_long = 0;
        alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
        mem_wb_valid = 0; mem_wb_rd = 0; mem_wb_data = 0;
    endtask

    task automatic iss(input logic [4:0] rs1, input logic [4:0] rd, input logic wr, input logic lng);
        issue_valid = 1; issue_rs1 = rs1; issue_rs2 = 0; issue_rs3 = 0;
        issue_rd = rd; issue_wr = wr; issue_long = lng;
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // One clock: check combinational outputs, advance the model, check state.
    task automatic cycle();
        bit ga, gm, any, stall, fire;
        logic [4:0] wrd;
        logic [31:0] wdat;
        bit eff[32];
        #1;
        ga = 0; gm = 0;
        if (alu_wb_valid && mem_wb_valid) begin
            ga = m_last_mem; gm = !m_last_mem;
        end else begin
            ga = alu_wb_valid; gm = mem_wb_valid;
        end
        any  = ga || gm;
        wrd  = gm ? mem_wb_rd : alu_wb_rd;
        wdat = gm ? mem_wb_data : alu_wb_data;
        for (int r = 0; r < 32; r++) eff[r] = m_busy[r] && !(any && wrd == 5'(r) && r != 0);
        stall = issue_valid && (
                 (issue_rs1 != 0 && eff[issue_rs1]) || (issue_rs2 != 0 && eff[issue_rs2]) ||
                 (issue_rs3 != 0 && eff[issue_rs3]) ||
                 (issue_wr && issue_rd != 0 && eff[issue_rd]) ||
                 (issue_wr && issue_long && m_cnt == MAXL));
        fire = issue_valid && !stall;
        if (!reset) begin
            chk("stall", 32'(issue_stall), 32'(stall));
            chk("alu_ready", 32'(alu_wb_ready), 32'(ga));
            chk("mem_ready", 32'(mem_wb_ready), 32'(gm));
            chk("rf_we", 32'(rf_we), 32'(any && wrd != 0));
            if (any) begin
                chk("rf_rd", 32'(rf_rd), 32'(wrd));
                chk("rf_wdata", rf_wdata, wdat);
            end
        end
        @(posedge clk);
        if (reset) begin
            for (int r = 0; r < 32; r++) m_busy[r] = 0;
            m_cnt = 0; m_last_mem = 1; m_err = 0;
        end else begin
            if (any) m_last_mem = gm;
            if (any && wrd != 0) begin
                if (!m_busy[wrd]) m_err = 1;
                m_busy[wrd] = 0;
                if (gm && m_cnt > 0) m_cnt--;
            end
            if (fire && issue_wr && issue_rd != 0) begin
                m_busy[issue_rd] = 1;
                if (issue_long) m_cnt++;
            end
        end
        #1;
        chk("busy", busy, model_busy());
        chk("long_cnt", 32'(long_cnt), 32'(m_cnt));
        chk("err", 32'(err_spurious), 32'(m_err));
    endtask

    task automatic do_reset();
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            issue_valid = 1'($urandom); issue_rs1 = 5'($urandom); issue_rs2 = 5'($urandom);
            issue_rs3 = 5'($urandom); issue_rd = 5'($urandom); issue_wr = 1'($urandom);
            issue_long = 1'($urandom); alu_wb_valid = 1'($urandom); alu_wb_rd = 5'($urandom);
            alu_wb_data = $urandom; mem_wb_valid = 1'($urandom); mem_wb_rd = 5'($urandom);
            mem_wb_data = $urandom;
            cycle();
        end
        reset = 0;
        idle();
    endtask

    initial begin
        logic [4:0] ar[4];
        logic [4:0] mr[4];
        idle();
        reset = 1;
        @(posedge clk); #1;

        // Reset with random inputs, then release
        do_reset();
        #1;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        cycle();
        chk("rst_busy", busy, 32'd0);
        chk("rst_long", 32'(long_cnt), 32'd0);
        chk("rst_err", 32'(err_spurious), 32'd0);

        // RAW stall then release by same-cycle ALU writeback
        iss(0, 5, 1, 0); cycle();
        iss(5, 0, 0, 0); #1;
        chk("raw_stall", 32'(issue_stall), 32'd1);
        cycle();
        alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_data = 32'hDEADBEEF; #1;
        chk("raw_release", 32'(issue_stall), 32'd0);
        chk("raw_rf_we", 32'(rf_we), 32'd1);
        chk("raw_rf_rd", 32'(rf_rd), 32'd5);
        chk("raw_rf_wdata", rf_wdata, 32'hDEADBEEF);
        cycle();
        chk("raw_busy5", 32'(busy[5]), 32'd0);
        idle();

        // Round-robin contention from a fresh arbiter
        do_reset();
        ar = '{5'd3, 5'd6, 5'd10, 5'd13};
        mr = '{5'd4, 5'd7, 5'd11, 5'd14};
        for (int i = 0; i < 4; i++) begin
            iss(0, ar[i], 1, 0); cycle();
            iss(0, mr[i], 1, 1); cycle();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            alu_wb_valid = 1; alu_wb_rd = ar[i]; alu_wb_data = $urandom;
            mem_wb_valid = 1; mem_wb_rd = mr[i]; mem_wb_data = $urandom;
            #1;
            chk("rr_alu_ready", 32'(alu_wb_ready), 32'(i % 2 == 0));
            chk("rr_mem_ready", 32'(mem_wb_ready), 32'(i % 2 == 1));
            cycle();
        end
        idle();

        // Long-op limit
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            iss(0, 5'(i), 1, 1); cycle();
        end
        iss(0, 5, 1, 1); #1;
        chk("long_full_stall", 32'(issue_stall), 32'd1);
        chk("long_full_cnt", 32'(long_cnt), 32'(MAXL));
        cycle();
        mem_wb_valid = 1; mem_wb_rd = 1; mem_wb_data = 32'h1234; #1;
        chk("long_grant_stall", 32'(issue_stall), 32'd1);
        cycle();
        mem_wb_valid = 0; #1;
        chk("long_after_fire", 32'(issue_stall), 32'd0);
        cycle();
        chk("long_cnt_after", 32'(long_cnt), 32'(MAXL));
        idle();

        // r0 destination and WAW
        do_reset();
        iss(0, 0, 1, 0); cycle();
        chk("r0_busy", busy, 32'd0);
        iss(0, 9, 1, 0); cycle();
        #1;
        chk("waw_stall", 32'(issue_stall), 32'd1);
        cycle();
        alu_wb_valid = 1; alu_wb_rd = 9; alu_wb_data = 32'h99; #1;
        chk("waw_release", 32'(issue_stall), 32'd0);
        cycle();
        chk("waw_busy9", 32'(busy[9]), 32'd1);
        idle();

        // Spurious writeback is written and flagged sticky
        do_reset();
        alu_wb_valid = 1; alu_wb_rd = 12; alu_wb_data = 32'hC0FFEE; #1;
        chk("spur_rf_we", 32'(rf_we), 32'd1);
        cycle();
        idle();
        cycle(); cycle();
        chk("spur_sticky", 32'(err_spurious), 32'd1);
        do_reset();
        cycle();
        chk("spur_cleared", 32'(err_spurious), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            issue_valid  = 1'($urandom);
            issue_rs1    = 5'($urandom_range(0, 7));
            issue_rs2    = 5'($urandom_range(0, 7));
            issue_rs3    = 5'($urandom_range(0, 7));
            issue_rd     = 5'($urandom_range(0, 7));
            issue_wr     = 1'($urandom);
            issue_long   = 1'($urandom);
            alu_wb_valid = 1'($urandom);
            alu_wb_rd    = 5'($urandom_range(0, 7));
            alu_wb_data  = $urandom;
            mem_wb_valid = 1'($urandom);
            mem_wb_rd    = 5'($urandom_range(0, 7));
            mem_wb_data  = $urandom;
            cycle();
        end
        reset = 0;
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
